// File: rtl/fetch_instr_gen_udiv_32ns_16ns_seq.sv
// Sequential restoring radix-2 unsigned divider for fetch address decode.
// Produces one quotient bit per cycle behind valid/ready handshakes.
// Divide-by-zero returns an all-ones quotient, the low dividend bits as the
// remainder, and raises div_by_zero.
module fetch_instr_gen_udiv_32ns_16ns_seq #(
  parameter int DIVIDEND_WIDTH = 32,
  parameter int DIVISOR_WIDTH  = 16
) (
  input  logic                      ap_clk,
  input  logic                      ap_rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DIVIDEND_WIDTH-1:0] dividend,
  input  logic [DIVISOR_WIDTH-1:0]  divisor,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DIVIDEND_WIDTH-1:0] quotient,
  output logic [DIVISOR_WIDTH-1:0]  remainder,
  output logic                      div_by_zero
);

  localparam int CW = $clog2(DIVIDEND_WIDTH);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t                    state, state_nxt;
  logic [DIVISOR_WIDTH-1:0]  dvs;
  logic [DIVISOR_WIDTH-1:0]  rem;
  logic [DIVIDEND_WIDTH-1:0] q;
  logic [CW-1:0]             cnt;
  logic                      dbz;

  // Shifted trial value is one bit wider than the divisor so it never
  // overflows. The stored remainder is always < divisor, so it needs only
  // DIVISOR_WIDTH bits; the extra bit of the partial remainder lives in t.
  logic [DIVISOR_WIDTH:0]    t, diff;
  logic                      ge;

  logic                      accept, handoff;

  assign accept  = (state == IDLE) && in_valid;
  assign handoff = (state == DONE) && out_ready;

  // Trial subtraction; because rem < divisor, t < 2*divisor, so the top bit
  // of the difference is exactly the borrow (set when t < divisor).
  always_comb begin
    t    = {rem, q[DIVIDEND_WIDTH-1]};
    diff = t - {1'b0, dvs};
    ge   = ~diff[DIVISOR_WIDTH];
  end

  // State register.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (in_valid) state_nxt = (divisor == '0) ? DONE : CALC;
      CALC: if (cnt == '0) state_nxt = DONE;
      DONE: if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: operand load, one restoring step per CALC cycle, flag clear.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      dvs <= '0;
      rem <= '0;
      q   <= '0;
      cnt <= '0;
      dbz <= 1'b0;
    end else if (accept) begin
      if (divisor == '0) begin
        q   <= '1;
        rem <= dividend[DIVISOR_WIDTH-1:0];
        dbz <= 1'b1;
      end else begin
        dvs <= divisor;
        q   <= dividend;
        rem <= '0;
        cnt <= CW'(DIVIDEND_WIDTH - 1);
        dbz <= 1'b0;
      end
    end else if (state == CALC) begin
      q   <= {q[DIVIDEND_WIDTH-2:0], ge};
      rem <= ge ? diff[DIVISOR_WIDTH-1:0] : t[DIVISOR_WIDTH-1:0];
      cnt <= cnt - 1'b1;
    end else if (handoff) begin
      dbz <= 1'b0;
    end
  end

  assign in_ready    = (state == IDLE);
  assign out_valid   = (state == DONE);
  assign quotient    = q;
  assign remainder   = rem;
  assign div_by_zero = dbz;

endmodule

// File: tb/tb_fetch_instr_gen_udiv_32ns_16ns_seq.sv
// Directed plus round-trip random bench for the sequential divider.
// Expected results are queued at drive time and popped at handoff.
module tb_fetch_instr_gen_udiv_32ns_16ns_seq;

  logic        ap_clk = 1'b0;
  logic        ap_rst;
  logic        in_valid, in_ready;
  logic [31:0] dividend;
  logic [15:0] divisor;
  logic        out_valid, out_ready;
  logic [31:0] quotient;
  logic [15:0] remainder;
  logic        div_by_zero;

  typedef struct {
    logic [31:0] q;
    logic [15:0] r;
    logic        dbz;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;

  fetch_instr_gen_udiv_32ns_16ns_seq #(
    .DIVIDEND_WIDTH(32),
    .DIVISOR_WIDTH (16)
  ) dut (
    .ap_clk     (ap_clk),
    .ap_rst     (ap_rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .dividend   (dividend),
    .divisor    (divisor),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 ap_clk = ~ap_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one division, wait for the result, optionally hold off the
  // consumer, then compare against the queued expectation and hand off.
  task automatic divide(input logic [31:0] a, input logic [15:0] b,
                        input logic [31:0] eq, input logic [15:0] er, input logic ed,
                        input int in_stall, input int out_stall,
                        input int exp_lat, input bit chk_hold);
    exp_t e;
    int   n;
    e.q = eq; e.r = er; e.dbz = ed;
    sb.push_back(e);
    in_valid = 1'b0;
    repeat (in_stall) @(negedge ap_clk);
    dividend = a;
    divisor  = b;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 200) begin @(negedge ap_clk); n++; end
    check("in_ready_wait", in_ready, 1'b1);
    @(negedge ap_clk);
    in_valid = 1'b0;
    dividend = $urandom;
    divisor  = 16'($urandom);
    n = 1;
    while (!out_valid && n < 200) begin @(negedge ap_clk); n++; end
    if (exp_lat > 0) check("latency", n, exp_lat);
    check("out_valid", out_valid, 1'b1);
    repeat (out_stall) begin
      @(negedge ap_clk);
      if (chk_hold) begin
        check("hold_valid", out_valid, 1'b1);
        check("hold_in_ready", in_ready, 1'b0);
        check("hold_q", quotient, eq);
        check("hold_r", remainder, er);
      end
    end
    e = sb.pop_front();
    check("quotient", quotient, e.q);
    check("remainder", remainder, e.r);
    check("div_by_zero", div_by_zero, e.dbz);
    out_ready = 1'b1;
    @(negedge ap_clk);
    out_ready = 1'b0;
    check("in_ready_after", in_ready, 1'b1);
    check("out_valid_after", out_valid, 1'b0);
    check("dbz_after", div_by_zero, 1'b0);
  endtask

  initial begin
    logic [31:0] a32, b32, r32, dv;
    ap_rst    = 1'b1;
    in_valid  = 1'b1;   // must be ignored while in reset
    dividend  = 32'd5;
    divisor   = 16'd0;
    out_ready = 1'b0;
    repeat (3) @(negedge ap_clk);
    ap_rst   = 1'b0;
    in_valid = 1'b0;
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_q", quotient, 32'd0);
    check("rst_r", remainder, 16'd0);
    check("rst_dbz", div_by_zero, 1'b0);

    divide(32'd1000, 16'd7, 32'd142, 16'd6, 1'b0, 0, 0, 33, 1'b0);
    divide(32'hFFFF_FFFF, 16'hFFFF, 32'h0001_0001, 16'd0, 1'b0, 0, 0, 33, 1'b0);
    divide(32'd3, 16'd10, 32'd0, 16'd3, 1'b0, 0, 0, 33, 1'b0);
    divide(32'd5, 16'd0, 32'hFFFF_FFFF, 16'd5, 1'b1, 0, 0, 1, 1'b0);
    divide(32'd1000, 16'd7, 32'd142, 16'd6, 1'b0, 0, 0, 33, 1'b0);
    divide(32'd100, 16'd9, 32'd11, 16'd1, 1'b0, 0, 20, 33, 1'b1);

    // Reset in the middle of CALC aborts the division.
    dividend = 32'd123456;
    divisor  = 16'd77;
    in_valid = 1'b1;
    @(negedge ap_clk);
    in_valid = 1'b0;
    repeat (10) @(negedge ap_clk);
    check("mid_calc_busy", in_ready, 1'b0);
    ap_rst = 1'b1;
    @(negedge ap_clk);
    ap_rst = 1'b0;
    check("abort_in_ready", in_ready, 1'b1);
    check("abort_out_valid", out_valid, 1'b0);
    check("abort_q", quotient, 32'd0);
    check("abort_r", remainder, 16'd0);
    check("abort_dbz", div_by_zero, 1'b0);
    divide(32'd65535, 16'd255, 32'd257, 16'd0, 1'b0, 0, 0, 33, 1'b0);

    // Round-trip: dividend built from a*b+r must decompose back to a, r.
    for (int i = 0; i < 1000; i++) begin
      a32 = $urandom_range(0, 65535);
      b32 = $urandom_range(1, 65535);
      r32 = $urandom_range(0, b32 - 1);
      dv  = a32 * b32 + r32;
      divide(dv, b32[15:0], a32, r32[15:0], 1'b0,
             $urandom_range(0, 3), $urandom_range(0, 3), 0, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
